// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding and frame/kernel size helpers used by
// the conv_seq layer sequencer and its weight/bias bank.
package conv_pkg;

    // Layer-run phases of the sequencer.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_B = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    // Number of weight bytes in one layer configuration.
    function automatic int calc_nw(input int filter_size, input int channel_len);
        return filter_size * filter_size * channel_len;
    endfunction

    // Number of bias bytes in one layer configuration.
    function automatic int calc_nb(input int channel_len);
        return channel_len;
    endfunction

    // Number of input pixels in one frame.
    function automatic int calc_np(input int width, input int height);
        return width * height;
    endfunction

    // Number of valid-convolution results produced per frame.
    function automatic int calc_no(input int width, input int height, input int filter_size);
        return (width - filter_size + 1) * (height - filter_size + 1);
    endfunction

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/conv_seq_bank.sv
// conv_seq_bank: byte-indexed weight and bias register banks. The sequencer
// supplies a byte index and a write strobe per bank; banks hold their
// contents until overwritten and clear on reset.
module conv_seq_bank
    import conv_pkg::*;
#(
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int CHANNEL_LEN = 3,
    parameter int IDX_W       = cnt_bits(calc_nw(FILTER_SIZE, CHANNEL_LEN))
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   w_we_i,
    input  logic                                                   b_we_i,
    input  logic [IDX_W-1:0]                                       idx_i,
    input  logic [DATA_BITS-1:0]                                   data_i,
    output logic [calc_nw(FILTER_SIZE, CHANNEL_LEN)*DATA_BITS-1:0] weight_o,
    output logic [calc_nb(CHANNEL_LEN)*DATA_BITS-1:0]              bias_o
);

    localparam int NW = calc_nw(FILTER_SIZE, CHANNEL_LEN);
    localparam int NB = calc_nb(CHANNEL_LEN);

    logic [NW*DATA_BITS-1:0] weight_q;
    logic [NB*DATA_BITS-1:0] bias_q;

    // Weight bank: the byte lane selected by idx_i captures data_i on a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q <= '0;
        end else if (w_we_i) begin
            for (int k = 0; k < NW; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    weight_q[k*DATA_BITS +: DATA_BITS] <= data_i;
                end
            end
        end
    end

    // Bias bank: same indexed byte write, one lane per output channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (b_we_i) begin
            for (int k = 0; k < NB; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    bias_q[k*DATA_BITS +: DATA_BITS] <= data_i;
                end
            end
        end
    end

    assign weight_o = weight_q;
    assign bias_o   = bias_q;

endmodule

// File: rtl/conv_seq.sv
// conv_seq: layer-run sequencer for a streaming convolution datapath.
// A start in IDLE loads weights then biases over the cfg byte channel,
// forwards one frame of pixels to the datapath with zero latency, then waits
// for all results before pulsing done.
// Optional macro CONV_SEQ_TIMEOUT_EN adds a drain watchdog: if no result
// arrives for TIMEOUT cycles while draining, the run is abandoned and the
// sticky err flag is raised. Without the macro err is tied low.
module conv_seq
    import conv_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int CHANNEL_LEN = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic                                                 cfg_val,
    input  logic [DATA_BITS-1:0]                                 cfg_data,
    output logic                                                 cfg_rdy,
    input  logic                                                 pix_val,
    input  logic [DATA_BITS-1:0]                                 pix_data,
    output logic                                                 pix_rdy,
    output logic                                                 conv_in_val,
    output logic [DATA_BITS-1:0]                                 conv_data_in,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS*CHANNEL_LEN-1:0] conv_weight,
    output logic [CHANNEL_LEN*DATA_BITS-1:0]                     conv_bias,
    input  logic                                                 conv_out_val,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 err
);

    localparam int NW = calc_nw(FILTER_SIZE, CHANNEL_LEN);
    localparam int NB = calc_nb(CHANNEL_LEN);
    localparam int NP = calc_np(WIDTH, HEIGHT);
    localparam int NO = calc_no(WIDTH, HEIGHT, FILTER_SIZE);
    localparam int CW = cnt_bits(NW);
    localparam int PW = cnt_bits(NP);
    localparam int OW = cnt_bits(NO);

    state_e        state_q, state_d;
    logic [CW-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic          busy_q;

    logic cfg_fire;
    logic pix_fire;
    logic out_hit;
    logic out_full;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TW = cnt_bits(TIMEOUT);
    logic [TW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic          wd_expire;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    assign cfg_rdy      = (state_q == LOAD_W) || (state_q == LOAD_B);
    assign pix_rdy      = (state_q == STREAM) && (pix_cnt_q < PW'(NP));
    assign cfg_fire     = cfg_val && cfg_rdy;
    assign pix_fire     = pix_val && pix_rdy;
    assign conv_in_val  = pix_fire;
    assign conv_data_in = pix_data;

    // Results count only while a frame is in flight and never past NO.
    assign out_full = (out_cnt_q == OW'(NO));
    assign out_hit  = conv_out_val && !out_full &&
                      ((state_q == STREAM) || (state_q == DRAIN));

    // done is a decode of registered state: one cycle, the cycle after the last result.
    assign done = (state_q == DRAIN) && out_full;
    assign busy = busy_q;

`ifdef CONV_SEQ_TIMEOUT_EN
    assign wd_expire = (state_q == DRAIN) && !out_full && !conv_out_val &&
                       (wd_q == TW'(TIMEOUT - 1));
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and counter update for the run phases.
    always_comb begin
        state_d   = state_q;
        cfg_cnt_d = cfg_cnt_q;
        pix_cnt_d = pix_cnt_q;
        out_cnt_d = out_cnt_q;
`ifdef CONV_SEQ_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_W;
                    cfg_cnt_d = '0;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
`ifdef CONV_SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            LOAD_W: begin
                if (cfg_fire) begin
                    if (cfg_cnt_q == CW'(NW - 1)) begin
                        state_d   = LOAD_B;
                        cfg_cnt_d = '0;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (cfg_fire) begin
                    if (cfg_cnt_q == CW'(NB - 1)) begin
                        state_d   = STREAM;
                        cfg_cnt_d = '0;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (pix_fire) begin
                    pix_cnt_d = pix_cnt_q + PW'(1);
                    if (pix_cnt_q == PW'(NP - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_full) begin
                    state_d = IDLE;
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (out_hit) begin
            out_cnt_d = out_cnt_q + OW'(1);
        end
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    // Watchdog restarts on DRAIN entry and on every result strobe while draining.
    always_comb begin
        wd_d = wd_q;
        if ((state_q == STREAM) && (state_d == DRAIN)) begin
            wd_d = '0;
        end else if (state_q == DRAIN) begin
            if (conv_out_val) begin
                wd_d = '0;
            end else if (!wd_expire) begin
                wd_d = wd_q + TW'(1);
            end
        end
    end

    // Watchdog and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

    // FSM, counters and busy flag; busy tracks the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_cnt_q <= '0;
            pix_cnt_q <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_cnt_q <= cfg_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            out_cnt_q <= out_cnt_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    conv_seq_bank #(
        .FILTER_SIZE (FILTER_SIZE),
        .DATA_BITS   (DATA_BITS),
        .CHANNEL_LEN (CHANNEL_LEN),
        .IDX_W       (CW)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .w_we_i   ((state_q == LOAD_W) && cfg_fire),
        .b_we_i   ((state_q == LOAD_B) && cfg_fire),
        .idx_i    (cfg_cnt_q),
        .data_i   (cfg_data),
        .weight_o (conv_weight),
        .bias_o   (conv_bias)
    );

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: randomized scoreboard bench for conv_seq. The stimulus process
// pushes expected pixels and expected done cycles into queues; a negedge
// monitor pops and compares whenever the DUT strobes conv_in_val or done.
// With CONV_SEQ_TIMEOUT_EN defined the drain-watchdog run is also exercised.
module tb_conv_seq;

    localparam int WIDTH = 28;
    localparam int HEIGHT = 28;
    localparam int FS = 5;
    localparam int DB = 8;
    localparam int CH = 3;
    localparam int TO = 16;
    localparam int NW = FS * FS * CH;
    localparam int NB = CH;
    localparam int NP = WIDTH * HEIGHT;
    localparam int NO = (WIDTH - FS + 1) * (HEIGHT - FS + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               cfg_val;
    logic [DB-1:0]      cfg_data;
    logic               cfg_rdy;
    logic               pix_val;
    logic [DB-1:0]      pix_data;
    logic               pix_rdy;
    logic               conv_in_val;
    logic [DB-1:0]      conv_data_in;
    logic [NW*DB-1:0]   conv_weight;
    logic [NB*DB-1:0]   conv_bias;
    logic               conv_out_val;
    logic               busy;
    logic               done;
    logic               err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_in = 0;

    logic [DB-1:0] exp_pix[$];
    int            exp_done[$];
    logic [DB-1:0] mon_e;

    conv_seq #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FILTER_SIZE(FS),
        .DATA_BITS(DB), .CHANNEL_LEN(CH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_val(cfg_val), .cfg_data(cfg_data), .cfg_rdy(cfg_rdy),
        .pix_val(pix_val), .pix_data(pix_data), .pix_rdy(pix_rdy),
        .conv_in_val(conv_in_val), .conv_data_in(conv_data_in),
        .conv_weight(conv_weight), .conv_bias(conv_bias),
        .conv_out_val(conv_out_val), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pixels forwarded to the datapath and done pulses.
    always @(negedge clk) begin
        if (conv_in_val === 1'b1) begin
            n_in++;
            if (exp_pix.size() == 0) begin
                chk("pix_unexpected", conv_in_val, 0);
            end else begin
                mon_e = exp_pix.pop_front();
                chk("pix_data", conv_data_in, mon_e);
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) chk("done_unexpected", done, 0);
            else chk("done_cycle", cyc, exp_done.pop_front());
        end else if (exp_done.size() > 0 && cyc > exp_done[0]) begin
            chk("done_missing", done, 1);
            void'(exp_done.pop_front());
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_cfg_rdy"}, cfg_rdy, 0);
        chk({tag, "_pix_rdy"}, pix_rdy, 0);
        chk({tag, "_conv_in_val"}, conv_in_val, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_weight_zero"}, |conv_weight, 0);
        chk({tag, "_bias_zero"}, |conv_bias, 0);
    endtask

    // One config byte with a random idle gap; conv_out_val noise must be ignored.
    task automatic send_cfg(input logic [DB-1:0] b);
        int w;
        repeat ($urandom_range(0, 2)) begin
            conv_out_val = 1'($urandom_range(0, 1));
            tick();
        end
        conv_out_val = 1'b0;
        cfg_val = 1'b1;
        cfg_data = b;
        w = 0;
        while (cfg_rdy !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("cfg_rdy_wait", cfg_rdy, 1);
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic run_layer(input bit rand_w, input int n_out, input bit expect_timeout);
        logic [NW*DB-1:0] mw;
        logic [NB*DB-1:0] mb;
        logic [DB-1:0]    b;
        int out_sent;
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
        chk("cfg_rdy_load_w", cfg_rdy, 1);
        for (int i = 0; i < NW; i++) begin
            b = rand_w ? DB'($urandom) : DB'(i + 1);
            mw[i*DB +: DB] = b;
            send_cfg(b);
        end
        chk("cfg_rdy_load_b", cfg_rdy, 1);
        for (int i = 0; i < NB; i++) begin
            b = DB'($urandom);
            mb[i*DB +: DB] = b;
            send_cfg(b);
        end
        chk("cfg_rdy_after_bias", cfg_rdy, 0);
        chk("pix_rdy_stream", pix_rdy, 1);
        n_chk++;
        if (conv_weight !== mw) begin
            n_fail++;
            $display("FAIL weight_bank: got %h expected %h", conv_weight, mw);
        end
        chk("bias_bank", conv_bias, 64'(mb));

        n_in = 0;
        out_sent = 0;
        for (int i = 0; i < NP; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    pix_val = 1'b0;
                    pix_data = DB'($urandom);
                    tick();
                end
            end
            pix_val = 1'b1;
            pix_data = DB'($urandom);
            exp_pix.push_back(pix_data);
            start = (i == 300);
            if (out_sent < 100 && $urandom_range(0, 7) == 0) begin
                conv_out_val = 1'b1;
                out_sent++;
            end
            tick();
            start = 1'b0;
            conv_out_val = 1'b0;
            if (i == 300) begin
                chk("start_in_stream_cfg_rdy", cfg_rdy, 0);
                chk("start_in_stream_pix_rdy", pix_rdy, 1);
            end
        end
        chk("pix_rdy_after_last", pix_rdy, 0);
        chk("busy_in_drain", busy, 1);
        repeat (3) tick();
        pix_val = 1'b0;
        chk("pixel_count", n_in, NP);

        while (out_sent < n_out) begin
            repeat ($urandom_range(0, 4)) tick();
            conv_out_val = 1'b1;
            out_sent++;
            if (out_sent == n_out && !expect_timeout) exp_done.push_back(cyc + 1);
            tick();
            conv_out_val = 1'b0;
        end

        if (!expect_timeout) begin
            chk("done_pulse", done, 1);
            tick();
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            repeat (3) begin
                conv_out_val = 1'b1;
                tick();
            end
            conv_out_val = 1'b0;
            chk("idle_cfg_rdy", cfg_rdy, 0);
            chk("idle_pix_rdy", pix_rdy, 0);
        end else begin
            k = 0;
            while (err !== 1'b1 && k < 100) begin
                tick();
                k++;
            end
            chk("timeout_latency", k, TO);
            chk("timeout_busy", busy, 0);
            chk("timeout_done", done, 0);
            repeat (3) tick();
            chk("err_sticky", err, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_val = 1'b0;
        cfg_data = '0;
        pix_val = 1'b0;
        pix_data = '0;
        conv_out_val = 1'b0;
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Reset in the middle of weight loading abandons the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) send_cfg(DB'(8'hA0 + i));
        chk("partial_weight_byte0", conv_weight[DB-1:0], 8'hA0);
        chk("partial_busy", busy, 1);
        #2 rst = 1'b1;
        #1 chk_quiet("mid_load_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk_quiet("post_reset");

        run_layer(1'b0, NO, 1'b0);
`ifdef CONV_SEQ_TIMEOUT_EN
        run_layer(1'b1, 500, 1'b1);
        run_layer(1'b1, NO, 1'b0);
`else
        run_layer(1'b1, NO, 1'b0);
        chk("err_tied_low", err, 0);
`endif
        repeat (4) tick();
        chk("pix_queue_drained", exp_pix.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout: simulation did not finish within the cycle budget");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 28, input frame columns
- HEIGHT, 28, input frame rows
- FILTER_SIZE, 5, kernel edge
- DATA_BITS, 8, pixel/weight/bias width
- CHANNEL_LEN, 3, output channels
- TIMEOUT, 1024, drain watchdog cycles
REQ-002 The block SHALL have these ports (name, direction, width, meaning); clock and reset are fixed: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin one layer run, sampled in IDLE
- cfg_val  in  1  config byte valid
- cfg_data  in  DATA_BITS  weight/bias byte
- cfg_rdy  out  1  config byte accepted when cfg_val&&cfg_rdy
- pix_val  in  1  pixel valid
- pix_data  in  DATA_BITS  pixel, raster order
- pix_rdy  out  1  pixel accepted when pix_val&&pix_rdy
- conv_in_val  out  1  pixel strobe to conv datapath
- conv_data_in  out  DATA_BITS  pixel to conv datapath
- conv_weight  out  FILTER_SIZE*FILTER_SIZE*DATA_BITS*CHANNEL_LEN  weight bank
- conv_bias  out  CHANNEL_LEN*DATA_BITS  bias bank
- conv_out_val  in  1  conv datapath result strobe
- busy  out  1  not IDLE
- done  out  1  one-cycle run-complete pulse
- err  out  1  sticky timeout flag (macro only; else tied 0)

Function
REQ-003 Constants: NW = FILTER_SIZE*FILTER_SIZE*CHANNEL_LEN, NB = CHANNEL_LEN, NP = WIDTH*HEIGHT, NO = (WIDTH-FILTER_SIZE+1)*(HEIGHT-FILTER_SIZE+1).
REQ-004 FSM states SHALL be IDLE, LOAD_W, LOAD_B, STREAM, DRAIN; start in IDLE -> LOAD_W; start in any other state ignored.
REQ-005 LOAD_W: cfg_rdy=1; k-th accepted byte (k=0..NW-1) written to conv_weight[k*DATA_BITS +: DATA_BITS]; after byte NW-1 -> LOAD_B.
REQ-006 LOAD_B: cfg_rdy=1; k-th byte to conv_bias[k*DATA_BITS +: DATA_BITS]; after byte NB-1 -> STREAM.
REQ-007 cfg_rdy SHALL be 0 outside LOAD_W/LOAD_B; banks hold their values until the next LOAD_W write.
REQ-008 STREAM: pix_rdy=1 while pixel count < NP; conv_in_val = pix_val&&pix_rdy and conv_data_in = pix_data combinationally (zero latency); after pixel NP-1 -> DRAIN.
REQ-009 Output counter increments on every conv_out_val in STREAM or DRAIN; DRAIN -> IDLE with done=1 for one cycle in the cycle after count reaches NO.
REQ-010 conv_out_val in IDLE, LOAD_W, LOAD_B SHALL be ignored; conv_out_val beyond NO ignored.
REQ-011 Counters: pixel 0..NP, output 0..NO, config 0..NW-1, each ceil(log2)+1 bits, cleared on entry to LOAD_W.
REQ-012 busy = (state != IDLE), registered with state.

Reset
REQ-013 rst asserted SHALL immediately force IDLE, clear all counters, conv_weight, conv_bias, done, err to 0; cfg_rdy, pix_rdy, conv_in_val, busy 0.
REQ-014 rst mid-run SHALL abandon the run with no done pulse; next run requires start.

Configuration
REQ-015 With CONV_SEQ_TIMEOUT_EN defined: a cycle counter restarts on entry to DRAIN and each conv_out_val; on reaching TIMEOUT -> IDLE, err set (sticky until rst or next start), no done.
REQ-016 Without CONV_SEQ_TIMEOUT_EN: DRAIN waits indefinitely; err tied 0; no watchdog counter.

Structure
REQ-017 Package conv_pkg SHALL hold the state enum and NW/NB/NP/NO helper functions.
REQ-018 Sub-module conv_seq_bank SHALL implement the indexed weight/bias write bank; FSM and counters stay in conv_seq.

Verification
REQ-019 Reset mid-LOAD_W (after 10 bytes) -> all outputs 0, state IDLE, banks cleared.
REQ-020 Defaults, start, 75 weight bytes 1..75, 3 bias bytes -> conv_weight byte k = k+1, conv_bias exact, cfg_rdy drops after byte 78.
REQ-021 784 pixels with random pix_val gaps -> conv_in_val count 784, data matches, pix_rdy 0 after 784th.
REQ-022 576 conv_out_val pulses -> done one cycle after the 576th, busy 0 next cycle.
REQ-023 start pulsed during STREAM -> no effect, counts unchanged.
REQ-024 Macro on, TIMEOUT=16, only 500 outputs -> err=1 16 cycles after last, IDLE, no done.
